// File: rtl/spi_byte_master_if.sv
// Sequencer-side handshake for the SPI byte master.
// master: command sequencer; slave: spi_byte_master.
interface spi_byte_master_if;
  logic       start;
  logic [7:0] tx_data;
  logic       cs_hold;
  logic       cs_release;
  logic       busy;
  logic       done;
  logic [7:0] rx_data;

  modport master (
    output start, tx_data, cs_hold, cs_release,
    input  busy, done, rx_data
  );

  modport slave (
    input  start, tx_data, cs_hold, cs_release,
    output busy, done, rx_data
  );
endinterface

// File: rtl/spi_byte_master.sv
// SPI mode-0 byte master with chip-select framing.
// Ports: clk, rst_l, bus (handshake), sck/mosi/cs_l out, miso in.
module spi_byte_master #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic              clk,
  input  logic              rst_l,
  spi_byte_master_if.slave  bus,
  output logic              sck,
  output logic              mosi,
  input  logic              miso,
  output logic              cs_l
);

  localparam logic [7:0] HM1 = 8'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE, SETUP, HIGH, LOW, TAIL
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] tx_q, tx_d;
  logic [7:0] rx_q, rx_d;
  logic [7:0] rxo_q, rxo_d;
  logic       hold_q, hold_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       sck_q, sck_d;
  logic       mosi_q, mosi_d;
  logic       cs_l_q, cs_l_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    rxo_d   = rxo_q;
    hold_d  = hold_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    sck_d   = sck_q;
    mosi_d  = mosi_q;
    cs_l_d  = cs_l_q;
    if (state_q != IDLE && cnt_q != 8'd0)
      cnt_d = cnt_q - 8'd1;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = SETUP;
          cnt_d   = HM1;
          bit_d   = 3'd0;
          tx_d    = bus.tx_data;
          hold_d  = bus.cs_hold;
          busy_d  = 1'b1;
          cs_l_d  = 1'b0;
          mosi_d  = bus.tx_data[7];
        end else if (bus.cs_release) begin
          cs_l_d = 1'b1;
        end
      end
      SETUP: begin
        if (cnt_q == 8'd0) begin
          state_d = HIGH;
          cnt_d   = HM1;
          sck_d   = 1'b1;
        end
      end
      HIGH: begin
        if (cnt_q == 8'd0) begin
          // sample on the edge that drops sck
          rx_d  = {rx_q[6:0], miso};
          cnt_d = HM1;
          sck_d = 1'b0;
          if (bit_q == 3'd7) begin
            state_d = TAIL;
          end else begin
            state_d = LOW;
            bit_d   = bit_q + 3'd1;
            mosi_d  = tx_q[6];
            tx_d    = {tx_q[6:0], 1'b0};
          end
        end
      end
      LOW: begin
        if (cnt_q == 8'd0) begin
          state_d = HIGH;
          cnt_d   = HM1;
          sck_d   = 1'b1;
        end
      end
      TAIL: begin
        if (cnt_q == 8'd0) begin
          state_d = IDLE;
          cnt_d   = 8'd0;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          rxo_d   = rx_q;
          cs_l_d  = ~hold_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      bit_q   <= 3'd0;
      tx_q    <= 8'd0;
      rx_q    <= 8'd0;
      rxo_q   <= 8'd0;
      hold_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sck_q   <= 1'b0;
      mosi_q  <= 1'b0;
      cs_l_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      rxo_q   <= rxo_d;
      hold_q  <= hold_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sck_q   <= sck_d;
      mosi_q  <= mosi_d;
      cs_l_q  <= cs_l_d;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.rx_data = rxo_q;
  assign sck         = sck_q;
  assign mosi        = mosi_q;
  assign cs_l        = cs_l_q;

endmodule

// File: doc/spi_byte_master.md
# spi_byte_master

Byte-wide SPI mode-0 master that drives the `sck`/`mosi`/`cs_l` pins and samples `miso` for the serial flash / SD-card port on `gpio`. It sits directly below the command sequencer in `top` and above the pins. The sequencer hands it one byte per `start` and receives one byte back per `done`. It also owns chip-select framing, so multi-byte commands (e.g. 48-bit commands, 512-byte blocks) stay under a single `cs_l` assertion.

## Interface
- `CLK_DIV`, default 2: SCK half-period in `clk` cycles (H); legal range 1..255.
- `clk` in 1: system clock; all logic on rising edge.
- `rst_l` in 1: reset is synchronous and active-low.
- `start` in 1: request one byte transfer; accepted only when `busy`=0.
- `tx_data` in 8: byte to send MSB first; captured when `start` is accepted.
- `cs_hold` in 1: captured with `start`.
  - 1: keep `cs_l` low after this byte.
  - 0: release `cs_l` at `done`.
- `cs_release` in 1: when idle, forces `cs_l` high on the next cycle; ignored while `busy`.
- `busy` out 1: transfer in progress.
- `done` out 1: one-cycle pulse; `rx_data` is valid from this cycle.
- `rx_data` out 8: last received byte; held until the next `done`.
- `sck` out 1: SPI clock, idle low.
- `mosi` out 1: serial data out.
- `miso` in 1: serial data in.
- `cs_l` out 1: chip select, active low.

## Operation
- States:
  - IDLE
  - SETUP (`cs_l` low, `sck` low, H cycles)
  - HIGH (`sck`=1, H cycles)
  - LOW (`sck`=0, H cycles)
  - TAIL (`sck`=0, H cycles after the 8th bit)
- IDLE + `start`:
  - Capture `tx_data` into the shift register and `cs_hold` into a flag.
  - Next cycle: SETUP, `busy`=1, `cs_l`=0, `mosi`=`tx_data[7]`.
- SETUP → HIGH after H cycles.
- HIGH → LOW after H cycles. On the last clk of HIGH (the edge returning `sck` low), shift `miso` into bit 0 of the rx shift register.
- LOW: present the next tx bit on `mosi` on the first cycle of LOW.
  - Bits 0..6: LOW → HIGH after H cycles.
  - After the 8th HIGH, go to TAIL instead of LOW.
- TAIL → IDLE after H cycles. In the IDLE entry cycle:
  - `done`=1, `busy`=0, `rx_data` updated.
  - `cs_l`=1 unless the captured `cs_hold`=1.
- A `start` in the same cycle as `done` is accepted; back-to-back bytes are legal.
  - `cs_hold`=1 keeps `cs_l` continuously low across bytes.
  - Otherwise `cs_l` is high for at least 1 cycle.
- `start` while `busy`=1 is ignored, with no queuing; `tx_data` changes while busy have no effect.
- `cs_release` and `start` in the same idle cycle: `start` wins and `cs_l` stays low.
- `mosi` holds its last bit when idle; it is 0 after reset.
- Bit counter is 3 bits and the half-period counter is 8 bits. Neither wraps mid-byte; both reload on every state change.

## Timing
- Reset values (`rst_l`=0 at a clk edge):
  - `cs_l`=1, `sck`=0, `mosi`=0, `busy`=0, `done`=0, `rx_data`=0x00.
  - State IDLE; captured `cs_hold`=0.
- Reset mid-transfer aborts at the next edge and produces no `done` pulse.
- Take `start` accepted at cycle 0:
  - `busy`/`cs_l` change at cycle 1.
  - k-th `sck` rise (k=0..7) at cycle 1+H+2kH.
  - Last `sck` fall at cycle 1+16H.
  - `done` at cycle 1+17H (35 for H=2; 18 for H=1).
- Throughput is 17H+1 cycles per byte when restarted on `done`.
- `miso` must be stable during the last clk of each HIGH phase. It may change after an `sck` fall, per mode 0.
- `mosi` is stable for at least H cycles before and after each `sck` rise.

## Test plan
- Reset: hold `rst_l`=0 for 2 cycles → `cs_l`=1, `sck`=0, `mosi`=0, `busy`=0, `done`=0, `rx_data`=0x00.
- Loopback (`miso`=`mosi`), CLK_DIV=2, `tx_data`=0xA5, `cs_hold`=0:
  - `sck` shows 8 pulses, each 2 high / 2 low.
  - `mosi` sampled at rises is 1,0,1,0,0,1,0,1.
  - `done` at cycle 35, `rx_data`=0xA5, `cs_l` high at cycle 35.
- `miso` tied 1, `tx_data`=0x00, CLK_DIV=1 → `done` at cycle 18, `rx_data`=0xFF, `mosi` 0 throughout.
- Framing: send 0x40 with `cs_hold`=1, then 0x95 with `cs_hold`=1 issued on the `done` cycle:
  - `cs_l` stays low across both bytes.
  - `cs_release` pulse while idle → `cs_l` high the next cycle.
- `start` with 0x3C at cycle 0, then `start` with 0xFF at cycle 10 (busy) → exactly one `done`, and loopback `rx_data`=0x3C.
- `rst_l` low at cycle 12 of a transfer → `cs_l`=1, `sck`=0, `busy`=0 next cycle; no `done` ever asserts; a subsequent transfer of 0x5A completes normally.
